pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage LC-3b pipeline. It drives the load strobes of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It also drives the bubble and flush controls that replace register contents with a NOP control word.
It resolves three conditions:
- cache-miss freezes, tracking one-cycle response pulses across split I/D memories;
- load-use hazards, resolved with a one-cycle bubble into ID/EX;
- taken-branch squashes, with the branch resolved in MEM.

Parameters:
CNT_W, 16, width of saturating performance counters

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
id_src1  in  3  SR1 of instruction in ID
id_src2  in  3  SR2 of instruction in ID
id_uses_src1  in  1  ID instruction reads id_src1
id_uses_src2  in  1  ID instruction reads id_src2
ex_valid  in  1  EX holds a real instruction (not a bubble)
ex_is_load  in  1  EX instruction is LDR/LDB/LDI (writes reg from memory)
ex_dest  in  3  destination register of EX instruction
imem_read  in  1  fetch outstanding; held high until the pipeline advances
imem_resp  in  1  one-cycle fetch-complete pulse
dmem_req  in  1  MEM-stage read or write outstanding; held high until advance
dmem_resp  in  1  one-cycle data-complete pulse
br_taken  in  1  MEM stage resolved a taken branch, JMP, JSR or TRAP
load_pc  out  1  PC register load
load_if_id  out  1  IF/ID load
load_id_ex  out  1  ID/EX load
load_ex_mem  out  1  EX/MEM load
load_mem_wb  out  1  MEM/WB load
bubble_id_ex  out  1  ID/EX captures the NOP control word instead of decode output
flush_if_id  out  1  IF/ID captures NOP on this load
flush_id_ex  out  1  ID/EX captures NOP on this load
flush_ex_mem  out  1  EX/MEM captures NOP on this load
stall_cycles  out  CNT_W  count of freeze cycles plus bubble cycles
flush_events  out  CNT_W  count of branch-flush cycles

Behaviour:
State (all reset asynchronously to 0): i_done, d_done, stall_cycles, flush_events.

Definitions:
- i_wait = imem_read & ~(imem_resp | i_done)
- d_wait = dmem_req & ~(dmem_resp | d_done)
- freeze = i_wait | d_wait
- lu_hazard = ex_valid & ex_is_load & ((id_uses_src1 & id_src1==ex_dest) | (id_uses_src2 & id_src2==ex_dest))

Outputs are combinational from state and inputs. Priority order is reset > freeze > br_taken > lu_hazard > run.

- Reset asserted: all load_* = 0; bubble and flush outputs = 0.
- Freeze: all load_* = 0; bubble and flush outputs = 0.
  - On posedge clk: i_done <= i_done | (imem_read & imem_resp); d_done <= d_done | (dmem_req & dmem_resp).
  - A response pulse that arrives while the other side still waits must not be lost.
- Advance (freeze = 0): i_done <= 0 and d_done <= 0 on the same edge.
- Branch (advance & br_taken):
  - all load_* = 1;
  - flush_if_id = flush_id_ex = flush_ex_mem = 1;
  - bubble_id_ex = 0.
  - lu_hazard is ignored, because the ID instruction is squashed.
- Load-use (advance & ~br_taken & lu_hazard):
  - load_pc = load_if_id = 0;
  - load_id_ex = load_ex_mem = load_mem_wb = 1;
  - bubble_id_ex = 1.
  - On the next cycle ex_valid = 0, so the bubble lasts exactly one cycle.
- Run: all load_* = 1; bubble and flush outputs = 0.
- Counters:
  - stall_cycles += 1 on each clock edge where freeze | (advance & ~br_taken & lu_hazard);
  - flush_events += 1 on each advance & br_taken edge;
  - both saturate at 2^CNT_W-1 (no wrap).
- Response pulse with read/req low: ignored, no flag set.
- Reset mid-freeze clears the flags immediately. The first cycle after reset release waits for a fresh resp.
- Register R0 is not special: a match on R0 still stalls.

Test Plan:
- Reset, then idle run (imem_read=1, imem_resp=1 each cycle) -> all loads 1, counters 0.
- imem_read high, imem_resp pulses at cycle 3; dmem_req high, dmem_resp pulses at cycle 5 -> loads 0 for cycles 0-4; i_done=1 from cycle 4; advance at cycle 5; flags 0 at cycle 6; stall_cycles=5.
- LDR R2 in EX (ex_valid=1, ex_is_load=1, ex_dest=2), ID ADD using src2=2 -> one cycle with load_pc=load_if_id=0, bubble_id_ex=1; next cycle with ex_valid=0 -> run; stall_cycles=1. Repeat with id_uses_src2=0 -> no stall.
- br_taken=1 with lu_hazard also true -> flushes 1, all loads 1, bubble 0; flush_events=1, stall_cycles unchanged.
- br_taken=1 during d_wait -> all loads 0, no flush until dmem_resp; flush asserted on the advance cycle only.
- CNT_W=2, hold freeze 6 cycles -> stall_cycles sticks at 3. Assert reset mid-freeze -> counters and flags 0 asynchronously.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage LC-3b pipeline: freezes on cache misses,
// bubbles ID/EX on load-use hazards and squashes younger stages on taken branches.
module pipe_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       id_src1,
  input  logic [2:0]       id_src2,
  input  logic             id_uses_src1,
  input  logic             id_uses_src2,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic [2:0]       ex_dest,
  input  logic             imem_read,
  input  logic             imem_resp,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  input  logic             br_taken,
  output logic             load_pc,
  output logic             load_if_id,
  output logic             load_id_ex,
  output logic             load_ex_mem,
  output logic             load_mem_wb,
  output logic             bubble_id_ex,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_ex_mem,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic [1:0] {
    MODE_HOLD,
    MODE_FLUSH,
    MODE_BUBBLE,
    MODE_RUN
  } mode_t;

  logic             r_iDone;
  logic             r_dDone;
  logic [CNT_W-1:0] r_stallCycles;
  logic [CNT_W-1:0] r_flushEvents;

  logic  w_iWait;
  logic  w_dWait;
  logic  w_freeze;
  logic  w_src1Hit;
  logic  w_src2Hit;
  logic  w_luHazard;
  logic  w_luStall;
  logic  w_brFlush;
  mode_t w_mode;

  // A side whose response already arrived stops waiting until the pipeline advances.
  assign w_iWait    = imem_read & ~(imem_resp | r_iDone);
  assign w_dWait    = dmem_req  & ~(dmem_resp | r_dDone);
  assign w_freeze   = w_iWait | w_dWait;

  assign w_src1Hit  = id_uses_src1 & (id_src1 == ex_dest);
  assign w_src2Hit  = id_uses_src2 & (id_src2 == ex_dest);
  assign w_luHazard = ex_valid & ex_is_load & (w_src1Hit | w_src2Hit);

  assign w_brFlush  = ~w_freeze & br_taken;
  assign w_luStall  = ~w_freeze & ~br_taken & w_luHazard;

  always_comb begin
    w_mode = MODE_RUN;
    if (reset || w_freeze) begin
      w_mode = MODE_HOLD;
    end else if (br_taken) begin
      w_mode = MODE_FLUSH;
    end else if (w_luHazard) begin
      w_mode = MODE_BUBBLE;
    end
  end

  always_comb begin
    load_pc      = 1'b0;
    load_if_id   = 1'b0;
    load_id_ex   = 1'b0;
    load_ex_mem  = 1'b0;
    load_mem_wb  = 1'b0;
    bubble_id_ex = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    case (w_mode)
      MODE_FLUSH: begin
        load_pc      = 1'b1;
        load_if_id   = 1'b1;
        load_id_ex   = 1'b1;
        load_ex_mem  = 1'b1;
        load_mem_wb  = 1'b1;
        flush_if_id  = 1'b1;
        flush_id_ex  = 1'b1;
        flush_ex_mem = 1'b1;
      end
      // PC and IF/ID hold the dependent instruction while a NOP enters EX.
      MODE_BUBBLE: begin
        load_id_ex   = 1'b1;
        load_ex_mem  = 1'b1;
        load_mem_wb  = 1'b1;
        bubble_id_ex = 1'b1;
      end
      MODE_RUN: begin
        load_pc      = 1'b1;
        load_if_id   = 1'b1;
        load_id_ex   = 1'b1;
        load_ex_mem  = 1'b1;
        load_mem_wb  = 1'b1;
      end
      default: begin
        load_pc      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_iDone <= 1'b0;
      r_dDone <= 1'b0;
    end else if (w_freeze) begin
      r_iDone <= r_iDone | (imem_read & imem_resp);
      r_dDone <= r_dDone | (dmem_req & dmem_resp);
    end else begin
      r_iDone <= 1'b0;
      r_dDone <= 1'b0;
    end
  end

  // Counters saturate rather than wrap so long runs never read as short ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stallCycles <= '0;
      r_flushEvents <= '0;
    end else begin
      if ((w_freeze | w_luStall) && (r_stallCycles != {CNT_W{1'b1}})) begin
        r_stallCycles <= r_stallCycles + CNT_W'(1);
      end
      if (w_brFlush && (r_flushEvents != {CNT_W{1'b1}})) begin
        r_flushEvents <= r_flushEvents + CNT_W'(1);
      end
    end
  end

  assign stall_cycles = r_stallCycles;
  assign flush_events = r_flushEvents;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a 16-bit-counter DUT and a 2-bit-counter DUT
// share stimulus and are compared every cycle against a behavioural model.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] id_src1 = '0, id_src2 = '0, ex_dest = '0;
  logic       id_uses_src1 = 1'b0, id_uses_src2 = 1'b0;
  logic       ex_valid = 1'b0, ex_is_load = 1'b0;
  logic       imem_read = 1'b0, imem_resp = 1'b0;
  logic       dmem_req = 1'b0, dmem_resp = 1'b0;
  logic       br_taken = 1'b0;

  logic       load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic       bubble_id_ex, flush_if_id, flush_id_ex, flush_ex_mem;
  logic [15:0] stall_cycles, flush_events;

  logic       sLoadPc, sLoadIfId, sLoadIdEx, sLoadExMem, sLoadMemWb;
  logic       sBubble, sFlushIfId, sFlushIdEx, sFlushExMem;
  logic [1:0] sStall, sFlush;

  int checks = 0;
  int passes = 0;

  int mStallBig = 0, mStallSmall = 0, mFlushBig = 0, mFlushSmall = 0;
  bit mIDone = 1'b0, mDDone = 1'b0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(16)) dutBig (
    .clk(clk), .reset(reset),
    .id_src1(id_src1), .id_src2(id_src2),
    .id_uses_src1(id_uses_src1), .id_uses_src2(id_uses_src2),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_dest(ex_dest),
    .imem_read(imem_read), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_resp(dmem_resp), .br_taken(br_taken),
    .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
    .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
    .bubble_id_ex(bubble_id_ex), .flush_if_id(flush_if_id),
    .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  pipe_hazard_ctrl #(.CNT_W(2)) dutSmall (
    .clk(clk), .reset(reset),
    .id_src1(id_src1), .id_src2(id_src2),
    .id_uses_src1(id_uses_src1), .id_uses_src2(id_uses_src2),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_dest(ex_dest),
    .imem_read(imem_read), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_resp(dmem_resp), .br_taken(br_taken),
    .load_pc(sLoadPc), .load_if_id(sLoadIfId), .load_id_ex(sLoadIdEx),
    .load_ex_mem(sLoadExMem), .load_mem_wb(sLoadMemWb),
    .bubble_id_ex(sBubble), .flush_if_id(sFlushIfId),
    .flush_id_ex(sFlushIdEx), .flush_ex_mem(sFlushExMem),
    .stall_cycles(sStall), .flush_events(sFlush)
  );

  // Model: a side is still waiting if its request is up and no response has been seen.
  function automatic bit modelFrozen();
    bit iPending = imem_read && !(imem_resp || mIDone);
    bit dPending = dmem_req && !(dmem_resp || mDDone);
    return iPending || dPending;
  endfunction

  function automatic bit modelHazard();
    bit readsDest = (id_uses_src1 && id_src1 == ex_dest) ||
                    (id_uses_src2 && id_src2 == ex_dest);
    return ex_valid && ex_is_load && readsDest;
  endfunction

  // Expected {5 loads, bubble, 3 flushes}.
  function automatic logic [8:0] modelCtl();
    if (reset || modelFrozen()) return 9'b00000_0_000;
    if (br_taken)               return 9'b11111_0_111;
    if (modelHazard())          return 9'b00111_1_000;
    return 9'b11111_0_000;
  endfunction

  function automatic int satInc(input int value, input int limit);
    return (value >= limit) ? limit : value + 1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mIDone <= 1'b0;
      mDDone <= 1'b0;
      mStallBig <= 0;
      mStallSmall <= 0;
      mFlushBig <= 0;
      mFlushSmall <= 0;
    end else begin
      if (modelFrozen()) begin
        mIDone <= mIDone || (imem_read && imem_resp);
        mDDone <= mDDone || (dmem_req && dmem_resp);
      end else begin
        mIDone <= 1'b0;
        mDDone <= 1'b0;
      end
      if (modelFrozen() || (!br_taken && modelHazard())) begin
        mStallBig   <= satInc(mStallBig, 65535);
        mStallSmall <= satInc(mStallSmall, 3);
      end
      if (!modelFrozen() && br_taken) begin
        mFlushBig   <= satInc(mFlushBig, 65535);
        mFlushSmall <= satInc(mFlushSmall, 3);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    else
      passes++;
  endtask

  always @(negedge clk) begin
    checkOutput("ctl_big", 32'({load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                                bubble_id_ex, flush_if_id, flush_id_ex, flush_ex_mem}),
                32'(modelCtl()));
    checkOutput("ctl_small", 32'({sLoadPc, sLoadIfId, sLoadIdEx, sLoadExMem, sLoadMemWb,
                                  sBubble, sFlushIfId, sFlushIdEx, sFlushExMem}),
                32'(modelCtl()));
    checkOutput("stall_big", 32'(stall_cycles), 32'(mStallBig));
    checkOutput("flush_big", 32'(flush_events), 32'(mFlushBig));
    checkOutput("stall_small", 32'(sStall), 32'(mStallSmall));
    checkOutput("flush_small", 32'(sFlush), 32'(mFlushSmall));
  end

  task automatic applyStimulus(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #1 reset = 1'b1;
    settle();
    checkOutput("reset_stall", 32'(stall_cycles), 32'd0);
    checkOutput("reset_load_pc", 32'(load_pc), 32'd0);
    applyStimulus(2);
    reset = 1'b0;

    // Idle run: fetch completes every cycle.
    imem_read = 1'b1;
    imem_resp = 1'b1;
    applyStimulus(4);
    checkOutput("idle_load_pc", 32'(load_pc), 32'd1);
    checkOutput("idle_stall", 32'(stall_cycles), 32'd0);

    // Split miss: fetch answers in cycle 3, data in cycle 5.
    dmem_req = 1'b1;
    for (int c = 0; c < 6; c++) begin
      imem_resp = (c == 3);
      dmem_resp = (c == 5);
      settle();
      checkOutput("miss_load_pc", 32'(load_pc), 32'(c == 5));
      applyStimulus(1);
    end
    dmem_req = 1'b0;
    dmem_resp = 1'b0;
    imem_resp = 1'b1;
    checkOutput("miss_stall", 32'(stall_cycles), 32'd5);
    checkOutput("miss_stall_sat", 32'(sStall), 32'd3);

    // Load-use: LDR R2 in EX, ID reads R2 through src2.
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_dest = 3'd2;
    id_src1 = 3'd5; id_uses_src1 = 1'b1; id_src2 = 3'd2; id_uses_src2 = 1'b1;
    settle();
    checkOutput("lu_bubble", 32'(bubble_id_ex), 32'd1);
    checkOutput("lu_load_pc", 32'(load_pc), 32'd0);
    checkOutput("lu_load_id_ex", 32'(load_id_ex), 32'd1);
    applyStimulus(1);
    ex_valid = 1'b0;
    settle();
    checkOutput("lu_after_load_pc", 32'(load_pc), 32'd1);
    applyStimulus(1);
    checkOutput("lu_stall", 32'(stall_cycles), 32'd6);
    ex_valid = 1'b1; id_uses_src2 = 1'b0;
    settle();
    checkOutput("nolu_bubble", 32'(bubble_id_ex), 32'd0);
    applyStimulus(1);
    ex_dest = 3'd0; id_src1 = 3'd0;
    settle();
    checkOutput("r0_bubble", 32'(bubble_id_ex), 32'd1);
    applyStimulus(1);
    checkOutput("r0_stall", 32'(stall_cycles), 32'd7);

    // Taken branch overrides the still-present R0 hazard.
    br_taken = 1'b1;
    settle();
    checkOutput("br_flush_if_id", 32'(flush_if_id), 32'd1);
    checkOutput("br_bubble", 32'(bubble_id_ex), 32'd0);
    checkOutput("br_load_pc", 32'(load_pc), 32'd1);
    applyStimulus(1);
    checkOutput("br_flush_events", 32'(flush_events), 32'd1);
    checkOutput("br_stall", 32'(stall_cycles), 32'd7);

    // Branch while data miss is pending: flush only on the advance cycle.
    ex_valid = 1'b0; dmem_req = 1'b1; dmem_resp = 1'b0;
    settle();
    checkOutput("brd_flush_held", 32'(flush_ex_mem), 32'd0);
    applyStimulus(2);
    dmem_resp = 1'b1;
    settle();
    checkOutput("brd_flush_adv", 32'(flush_ex_mem), 32'd1);
    applyStimulus(1);
    br_taken = 1'b0; dmem_req = 1'b0; dmem_resp = 1'b0;
    checkOutput("brd_flush_events", 32'(flush_events), 32'd2);
    checkOutput("brd_stall", 32'(stall_cycles), 32'd9);

    // Data pulse without a request must not mark the data side done.
    imem_resp = 1'b0; dmem_resp = 1'b1;
    applyStimulus(1);
    imem_resp = 1'b1; dmem_req = 1'b1; dmem_resp = 1'b0;
    settle();
    checkOutput("stray_pulse_load_pc", 32'(load_pc), 32'd0);
    applyStimulus(1);
    dmem_resp = 1'b1;
    applyStimulus(1);
    dmem_req = 1'b0; dmem_resp = 1'b0;
    checkOutput("stray_stall", 32'(stall_cycles), 32'd11);

    // Long freeze saturates the 2-bit counter.
    imem_resp = 1'b0;
    applyStimulus(6);
    checkOutput("sat_small", 32'(sStall), 32'd3);
    checkOutput("sat_big", 32'(stall_cycles), 32'd17);

    // Reset in the middle of a freeze with the fetch side already done.
    imem_resp = 1'b1; dmem_req = 1'b1;
    applyStimulus(1);
    imem_resp = 1'b0;
    applyStimulus(1);
    reset = 1'b1;
    settle();
    checkOutput("midrst_stall", 32'(stall_cycles), 32'd0);
    checkOutput("midrst_flush", 32'(flush_events), 32'd0);
    applyStimulus(1);
    reset = 1'b0; dmem_req = 1'b0;
    settle();
    checkOutput("postrst_wait_fetch", 32'(load_pc), 32'd0);
    applyStimulus(1);
    imem_resp = 1'b1;
    settle();
    checkOutput("postrst_advance", 32'(load_pc), 32'd1);
    applyStimulus(3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
